// File: rtl/meas_seq_ctrl.sv
// Measurement scheduler: a period timer launches scans that run one start/done
// transaction per enabled channel. Defining MEAS_SEQ_OVERRUN_EN adds sticky overrun_o.
module meas_seq_ctrl #(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255,
  localparam int CHW    = $clog2(NCH),
  localparam int TW     = $clog2(TIMEOUT + 1)
) (
  input  logic           clk,
  input  logic           reset_i,
  input  logic           en_i,
  input  logic [NCH-1:0] ch_en_i,
  input  logic [15:0]    period_i,
  output logic           meas_start_o,
  output logic [CHW-1:0] meas_ch_o,
  input  logic           meas_done_i,
  input  logic [DW-1:0]  meas_data_i,
  output logic           res_valid_o,
  output logic [CHW-1:0] res_ch_o,
  output logic [DW-1:0]  res_data_o,
  output logic           res_timeout_o,
`ifdef MEAS_SEQ_OVERRUN_EN
  output logic           overrun_o,
`endif
  output logic           busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_WAIT_DONE,
    S_EMIT
  } state_t;

  state_t         state_reg, state_next;
  logic [NCH-1:0] pend_reg, pend_next;
  logic [15:0]    cnt_reg, cnt_next;
  logic [TW-1:0]  timer_reg, timer_next;
  logic [CHW-1:0] meas_ch_reg, meas_ch_next;
  logic [CHW-1:0] res_ch_reg, res_ch_next;
  logic [DW-1:0]  res_data_reg, res_data_next;
  logic           res_timeout_reg, res_timeout_next;
`ifdef MEAS_SEQ_OVERRUN_EN
  logic           overrun_reg, overrun_next;
`endif

  logic           tick;
  logic           scan_busy;
  logic [NCH-1:0] scan_src;
  logic [NCH-1:0] first_oh;
  logic [CHW-1:0] first_idx;
  logic           first_found;

  assign tick      = en_i && (cnt_reg == 16'd0);
  assign scan_busy = (state_reg == S_START) || (state_reg == S_WAIT_DONE) ||
                     (state_reg == S_EMIT);

  // The channel picked on entry to START comes from the live mask at a tick,
  // or from the remaining pending mask when chaining out of EMIT.
  assign scan_src = (state_reg == S_WAIT_TICK) ? ch_en_i : pend_reg;

  always_comb begin
    first_oh    = '0;
    first_idx   = '0;
    first_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (scan_src[i] && !first_found) begin
        first_found = 1'b1;
        first_oh[i] = 1'b1;
        first_idx   = CHW'(i);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    pend_next        = pend_reg;
    cnt_next         = tick ? period_i : (cnt_reg - 16'd1);
    timer_next       = timer_reg;
    meas_ch_next     = meas_ch_reg;
    res_ch_next      = res_ch_reg;
    res_data_next    = res_data_reg;
    res_timeout_next = res_timeout_reg;
`ifdef MEAS_SEQ_OVERRUN_EN
    overrun_next     = overrun_reg | (tick & scan_busy);
`endif

    case (state_reg)
      S_IDLE: begin
        state_next = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (tick) begin
          pend_next = ch_en_i;
          if (ch_en_i != '0) begin
            state_next   = S_START;
            meas_ch_next = first_idx;
            pend_next    = ch_en_i & ~first_oh;
          end
        end
      end
      S_START: begin
        state_next = S_WAIT_DONE;
        timer_next = '0;
      end
      S_WAIT_DONE: begin
        timer_next = timer_reg + TW'(1);
        // A done on the last allowed cycle still counts as a real answer.
        if (meas_done_i) begin
          state_next       = S_EMIT;
          res_ch_next      = meas_ch_reg;
          res_data_next    = meas_data_i;
          res_timeout_next = 1'b0;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          state_next       = S_EMIT;
          res_ch_next      = meas_ch_reg;
          res_data_next    = '0;
          res_timeout_next = 1'b1;
        end
      end
      S_EMIT: begin
        if (pend_reg != '0) begin
          state_next   = S_START;
          meas_ch_next = first_idx;
          pend_next    = pend_reg & ~first_oh;
        end else begin
          state_next = S_WAIT_TICK;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Disabling behaves like a clear of everything on the next edge.
    if (!en_i) begin
      state_next       = S_IDLE;
      pend_next        = '0;
      cnt_next         = '0;
      timer_next       = '0;
      meas_ch_next     = '0;
      res_ch_next      = '0;
      res_data_next    = '0;
      res_timeout_next = 1'b0;
`ifdef MEAS_SEQ_OVERRUN_EN
      overrun_next     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_reg       <= S_IDLE;
      pend_reg        <= '0;
      cnt_reg         <= '0;
      timer_reg       <= '0;
      meas_ch_reg     <= '0;
      res_ch_reg      <= '0;
      res_data_reg    <= '0;
      res_timeout_reg <= 1'b0;
`ifdef MEAS_SEQ_OVERRUN_EN
      overrun_reg     <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      pend_reg        <= pend_next;
      cnt_reg         <= cnt_next;
      timer_reg       <= timer_next;
      meas_ch_reg     <= meas_ch_next;
      res_ch_reg      <= res_ch_next;
      res_data_reg    <= res_data_next;
      res_timeout_reg <= res_timeout_next;
`ifdef MEAS_SEQ_OVERRUN_EN
      overrun_reg     <= overrun_next;
`endif
    end
  end

  assign meas_start_o  = (state_reg == S_START);
  assign meas_ch_o     = meas_ch_reg;
  assign res_valid_o   = (state_reg == S_EMIT);
  assign res_ch_o      = res_ch_reg;
  assign res_data_o    = res_data_reg;
  assign res_timeout_o = res_timeout_reg;
  assign busy_o        = scan_busy;
`ifdef MEAS_SEQ_OVERRUN_EN
  assign overrun_o     = overrun_reg;
`endif

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Scoreboard bench for meas_seq_ctrl: a responder models the core, a transaction-level
// reference predicts starts/results, and a monitor compares them against the DUT.
module tb_meas_seq_ctrl;
  localparam int NCH     = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic [3:0]  ch_en_i;
  logic [15:0] period_i;
  logic        meas_start_o;
  logic [1:0]  meas_ch_o;
  logic        meas_done_i;
  logic [15:0] meas_data_i;
  logic        res_valid_o;
  logic [1:0]  res_ch_o;
  logic [15:0] res_data_o;
  logic        res_timeout_o;
  logic        busy_o;
`ifdef MEAS_SEQ_OVERRUN_EN
  logic        overrun_o;
`endif

  always #5 clk = ~clk;

  meas_seq_ctrl #(.NCH(NCH), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .en_i         (en_i),
    .ch_en_i      (ch_en_i),
    .period_i     (period_i),
    .meas_start_o (meas_start_o),
    .meas_ch_o    (meas_ch_o),
    .meas_done_i  (meas_done_i),
    .meas_data_i  (meas_data_i),
    .res_valid_o  (res_valid_o),
    .res_ch_o     (res_ch_o),
    .res_data_o   (res_data_o),
    .res_timeout_o(res_timeout_o),
`ifdef MEAS_SEQ_OVERRUN_EN
    .overrun_o    (overrun_o),
`endif
    .busy_o       (busy_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  typedef struct { int cyc; int ch; } start_t;
  typedef struct { int cyc; int ch; int data; int to; } res_t;

  start_t sq[$];
  res_t   rq[$];

  // ---------------- responder (models the measurement core) ----------------
  int resp_mode  = 0;
  int resp_lat   = 3;
  bit resp_flush = 1'b1;
  int done_cyc   = -1;
  int d_data     = 0;
  int r_ch, r_lat, r_dat, r_sel;
  res_t r_exp;

  initial begin
    meas_done_i = 1'b0;
    meas_data_i = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_flush) done_cyc = -1;
      if (meas_start_o) begin
        r_ch  = int'(meas_ch_o);
        r_dat = 'h1000 + r_ch;
        r_lat = resp_lat;
        case (resp_mode)
          1: if (r_ch == 1) r_lat = -1;
          2: begin r_lat = TIMEOUT; r_dat = 'hBEEF; end
          3: begin
            r_sel = $urandom_range(0, 19);
            if (r_sel == 0)      r_lat = 0;
            else if (r_sel == 1) r_lat = -1;
            else if (r_sel == 2) r_lat = TIMEOUT;
            else if (r_sel == 3) r_lat = TIMEOUT + 1;
            else                 r_lat = $urandom_range(1, 8);
            r_dat = $urandom_range(0, 65535);
          end
          default: ;
        endcase
        done_cyc = (r_lat < 0) ? -1 : cyc + r_lat;
        d_data   = r_dat;
        // Only a done strictly after the start cycle and within TIMEOUT waits counts.
        if (r_lat >= 1 && r_lat <= TIMEOUT) r_exp = '{cyc + r_lat + 1, r_ch, r_dat, 0};
        else                                 r_exp = '{cyc + TIMEOUT + 1, r_ch, 0, 1};
        rq.push_back(r_exp);
      end
      meas_done_i = (cyc == done_cyc);
      meas_data_i = meas_done_i ? 16'(d_data) : 16'($urandom);
    end
  end

  // ---------------- reference model + monitor ----------------
  bit phase_on    = 1'b0;
  int ph_e        = 0;
  int ph_p        = 0;
  bit scan_active = 1'b0;
  int scan_start  = 0;
  int ready       = 0;
  bit ovr_m       = 1'b0;
  int pend[$];
  int m_c;
  bit tick_now, busy_exp;
  start_t m_s;
  res_t   m_r;

  task automatic advance(int x);
    start_t s;
    if (pend.size() != 0) begin
      s.cyc = x + 1;
      s.ch  = pend.pop_front();
      sq.push_back(s);
    end else begin
      scan_active = 1'b0;
      ready       = x + 1;
    end
  endtask

  always @(negedge clk) begin
    m_c      = cyc;
    tick_now = phase_on && en_i && !reset_i && (((m_c - ph_e) % (ph_p + 1)) == 0);
    busy_exp = scan_active && (m_c >= scan_start);
    chk("busy", int'(busy_o), int'(busy_exp));
`ifdef MEAS_SEQ_OVERRUN_EN
    chk("overrun", int'(overrun_o), int'(ovr_m));
    if (tick_now && busy_exp) ovr_m = 1'b1;
`endif
    if (meas_start_o) begin
      if (sq.size() == 0) begin
        tests++; fails++;
        $display("FAIL start_unexpected at cycle %0d: got start ch %0d, expected none", m_c, meas_ch_o);
      end else begin
        m_s = sq.pop_front();
        chk("start_cycle", m_c, m_s.cyc);
        chk("start_ch", int'(meas_ch_o), m_s.ch);
      end
    end else if (sq.size() != 0 && sq[0].cyc <= m_c) begin
      m_s = sq.pop_front();
      tests++; fails++;
      $display("FAIL start_missing at cycle %0d: got none, expected start ch %0d at %0d", m_c, m_s.ch, m_s.cyc);
    end
    if (res_valid_o) begin
      if (rq.size() == 0) begin
        tests++; fails++;
        $display("FAIL result_unexpected at cycle %0d: got ch %0d data %0h, expected none", m_c, res_ch_o, res_data_o);
      end else begin
        m_r = rq.pop_front();
        chk("result_cycle", m_c, m_r.cyc);
        chk("result_ch", int'(res_ch_o), m_r.ch);
        chk("result_data", int'(res_data_o), m_r.data);
        chk("result_timeout", int'(res_timeout_o), m_r.to);
        advance(m_r.cyc);
      end
    end else if (rq.size() != 0 && rq[0].cyc <= m_c) begin
      m_r = rq.pop_front();
      tests++; fails++;
      $display("FAIL result_missing at cycle %0d: got none, expected ch %0d at %0d", m_c, m_r.ch, m_r.cyc);
      advance(m_r.cyc);
    end
    if (tick_now && !scan_active && m_c >= ready) begin
      pend.delete();
      for (int i = 0; i < NCH; i++) if (ch_en_i[i]) pend.push_back(i);
      if (pend.size() != 0) begin
        scan_active = 1'b1;
        scan_start  = m_c + 1;
        m_s.cyc     = m_c + 1;
        m_s.ch      = pend.pop_front();
        sq.push_back(m_s);
      end
    end
    if (reset_i || !en_i) begin
      phase_on    = 1'b0;
      scan_active = 1'b0;
      ovr_m       = 1'b0;
      pend.delete();
      sq.delete();
      rq.delete();
    end else if (!phase_on) begin
      phase_on = 1'b1;
      ph_e     = m_c;
      ph_p     = int'(period_i);
      ready    = m_c + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_zero(string name);
    chk(name, int'({meas_start_o, meas_ch_o, res_valid_o, res_ch_o, res_data_o, res_timeout_o, busy_o}), 0);
`ifdef MEAS_SEQ_OVERRUN_EN
    chk("overrun_zero", int'(overrun_o), 0);
`endif
  endtask

  task automatic run_phase(int p, logic [3:0] ce, int mode, int lat, int ncyc, bit rnd_ch);
    period_i   = 16'(p);
    ch_en_i    = ce;
    resp_mode  = mode;
    resp_lat   = lat;
    resp_flush = 1'b0;
    en_i       = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      step(1);
      if (rnd_ch && $urandom_range(0, 7) == 0) ch_en_i = 4'($urandom);
    end
  endtask

  task automatic end_phase();
    en_i       = 1'b0;
    resp_flush = 1'b1;
    step(3);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step(1);
      if (meas_start_o) ok = 1'b1;
    end
    chk("wait_start", int'(ok), 1);
  endtask

  bit ok;

  initial begin
    reset_i  = 1'b1;
    en_i     = 1'b0;
    ch_en_i  = '0;
    period_i = '0;
    step(3);
    chk_zero("reset_state");
    reset_i = 1'b0;
    step(2);
    chk_zero("disabled_idle");

    run_phase(99, 4'b1011, 0, 3, 350, 1'b0);
    end_phase();
    run_phase(299, 4'b0110, 1, 3, 700, 1'b0);
    end_phase();
    run_phase(299, 4'b0001, 2, 0, 600, 1'b0);
    end_phase();
    run_phase(5, 4'b0111, 0, 4, 120, 1'b0);
`ifdef MEAS_SEQ_OVERRUN_EN
    chk("overrun_set", int'(overrun_o), 1);
`endif
    end_phase();

    for (int k = 0; k < 4; k++) begin
      run_phase($urandom_range(0, 30), 4'($urandom), 3, 0, 500, 1'b1);
      end_phase();
    end

    // Abort during WAIT_DONE; the late done must be ignored.
    run_phase(999, 4'b0001, 0, 5, 0, 1'b0);
    wait_start(ok);
    if (ok) begin
      step(2);
      en_i = 1'b0;
      step(1);
      chk_zero("abort_zero");
      for (int i = 0; i < 6; i++) begin
        step(1);
        chk("abort_no_result", int'(res_valid_o), 0);
      end
    end
    end_phase();

    // Reset pulse mid-scan with enable held high.
    run_phase(0, 4'b1100, 0, 5, 0, 1'b0);
    wait_start(ok);
    if (ok) begin
      step(2);
      reset_i = 1'b1;
      step(1);
      reset_i = 1'b0;
      chk_zero("reset_mid_scan_zero");
      step(2);
      chk("restart_start", int'(meas_start_o), 1);
      chk("restart_ch", int'(meas_ch_o), 2);
    end
    step(20);
    end_phase();

    step(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule
